dcache_responder: RTL and testbench
===================================

DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 SHALL have parameter SETS, default 16, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter LINE_BITS, default 256, line width fetched from memory (8 words).
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ufp_addr  input  32  CPU request byte address; word-aligned.
REQ-006 SHALL have port ufp_rmask  input  4  byte read mask; nonzero = read request.
REQ-007 SHALL have port ufp_wmask  input  4  byte write mask; nonzero = write request.
REQ-008 SHALL have port ufp_wdata  input  32  store data, byte lanes per ufp_wmask.
REQ-009 SHALL have port ufp_rdata  output  32  load data; valid only while ufp_resp=1.
REQ-010 SHALL have port ufp_resp  output  1  one-cycle completion pulse for the current request.
REQ-011 SHALL have port dfp_addr  output  32  memory address: line-aligned for reads, word-aligned for writes.
REQ-012 SHALL have port dfp_read  output  1  line-fill request; held until dfp_resp.
REQ-013 SHALL have port dfp_write  output  1  write-through word request; held until dfp_resp.
REQ-014 SHALL have ports dfp_wmask (output, 4) and dfp_wdata (output, 32) for write-through data.
REQ-015 SHALL have ports dfp_rdata (input, LINE_BITS) and dfp_resp (input, 1); dfp_resp is a one-cycle pulse from memory.

Function
REQ-016 Address split SHALL be offset=addr[4:2], index=addr[4+log2(SETS):5], tag=remaining upper bits.
REQ-017 Policy SHALL be write-through, no-write-allocate; per line: valid bit, tag, 8 data words, all flop-based.
REQ-018 FSM states SHALL be IDLE, LOOKUP, FETCH, WRITE.
REQ-019 IDLE: rmask or wmask nonzero -> latch addr, masks, wdata; go to LOOKUP; if both nonzero, treat as write (rmask ignored).
REQ-020 LOOKUP read hit (valid and tag match): ufp_resp=1, ufp_rdata=selected word (full 32 bits, rmask not applied); -> IDLE.
REQ-021 LOOKUP read miss: -> FETCH.
REQ-022 FETCH: dfp_read=1, dfp_addr={addr[31:5],5'b0}; on dfp_resp install dfp_rdata, tag, and valid=1; -> LOOKUP (guaranteed hit, so a miss completes 1 cycle after fill).
REQ-023 LOOKUP write: on hit, merge wdata into the cached word per wmask; on miss, leave the cache unchanged; -> WRITE.
REQ-024 WRITE: dfp_write=1, dfp_addr={addr[31:2],2'b0}, dfp_wmask/dfp_wdata=latched values; on dfp_resp: ufp_resp=1; -> IDLE.
REQ-025 Latency (request first seen in IDLE = cycle 0) SHALL be: read hit, resp in cycle 1; read miss, resp 1 cycle after the dfp_resp cycle; write, resp in the same cycle as dfp_resp.
REQ-026 dfp_read and dfp_write SHALL never be asserted together; each SHALL be 0 outside its state.
REQ-027 The CPU holds its request stable until ufp_resp; the responder SHALL accept a new request in the cycle after ufp_resp (back-to-back).
REQ-028 dfp_resp arriving outside FETCH or WRITE SHALL be ignored.
REQ-029 A write hit followed by a read of the same address SHALL return the merged data without memory access.

Reset
REQ-030 On rst=1 at an edge: state=IDLE, all valid bits=0; ufp_resp, dfp_read, dfp_write=0 the next cycle; tag and data arrays are not cleared.
REQ-031 Reset mid-FETCH or mid-WRITE SHALL abandon the transaction, with no line install and no ufp_resp; a subsequent stray dfp_resp is ignored per REQ-028.

Verification
REQ-032 After reset, read 0x0000_1004 with rmask=4'hF; memory returns a line whose word1=0xDEAD_BEEF -> dfp_read with dfp_addr=0x0000_1000, then ufp_resp with rdata=0xDEAD_BEEF.
REQ-033 Re-read 0x0000_1004 -> ufp_resp in cycle 1 with 0xDEAD_BEEF, and dfp_read stays 0.
REQ-034 Write 0x0000_1004, wmask=4'b0011, wdata=0x1234_5678 -> dfp_write with dfp_addr=0x0000_1004; after dfp_resp, a read of 0x0000_1004 hits and returns 0xDEAD_5678.
REQ-035 Write a miss address 0x0000_2008 then read it -> write-through with no fill, then the read misses and issues dfp_read to 0x0000_2000.
REQ-036 Conflict: read 0x0000_1004 then 0x0000_3004 (same index 0, different tag) -> the second read misses and refills; a third read of 0x0000_1004 misses again.
REQ-037 Assert rst during FETCH, then pulse dfp_resp -> no ufp_resp, line 0 invalid, FSM in IDLE, dfp_read=0.

Source files
------------

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through / no-write-allocate data cache between a CPU request port
// and a line-fill memory port. Flop-based valid/tag/data arrays.
module dcache_responder #(
  parameter int unsigned SETS      = 16,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ufp_addr,
  input  logic [3:0]           ufp_rmask,
  input  logic [3:0]           ufp_wmask,
  input  logic [31:0]          ufp_wdata,
  output logic [31:0]          ufp_rdata,
  output logic                 ufp_resp,
  output logic [31:0]          dfp_addr,
  output logic                 dfp_read,
  output logic                 dfp_write,
  output logic [3:0]           dfp_wmask,
  output logic [31:0]          dfp_wdata,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  input  logic                 dfp_resp
);

  localparam int unsigned WORDS = 8;
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 27 - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FETCH, WRITE} state_t;

  state_t           state_q, state_d;
  logic [31:2]      addr_q, addr_d;
  logic             is_write_q, is_write_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [TAG_W-1:0] tag_d [SETS];
  logic [31:0]      data_q [SETS][WORDS];
  logic [31:0]      data_d [SETS][WORDS];

  logic [IDX_W-1:0] idx_c;
  logic [2:0]       off_c;
  logic [TAG_W-1:0] tag_c;
  logic             hit_c;
  logic [31:0]      word_c;

  // Lookup always works on the latched request address.
  assign idx_c  = addr_q[4+IDX_W:5];
  assign off_c  = addr_q[4:2];
  assign tag_c  = addr_q[31:5+IDX_W];
  assign word_c = data_q[idx_c][off_c];
  assign hit_c  = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    is_write_d = is_write_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    ufp_resp   = 1'b0;
    ufp_rdata  = 32'h0;
    unique case (state_q)
      IDLE: begin
        if ((ufp_rmask != 4'h0) || (ufp_wmask != 4'h0)) begin
          addr_d     = ufp_addr[31:2];
          is_write_d = (ufp_wmask != 4'h0);
          wmask_d    = ufp_wmask;
          wdata_d    = ufp_wdata;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (is_write_q) begin
          if (hit_c) begin
            for (int b = 0; b < 4; b++) begin
              if (wmask_q[b]) data_d[idx_c][off_c][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
          state_d = WRITE;
        end else if (hit_c) begin
          ufp_resp  = 1'b1;
          ufp_rdata = word_c;
          state_d   = IDLE;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (dfp_resp) begin
          for (int w = 0; w < int'(WORDS); w++) begin
            data_d[idx_c][w] = dfp_rdata[32*w +: 32];
          end
          tag_d[idx_c]   = tag_c;
          valid_d[idx_c] = 1'b1;
          state_d        = LOOKUP;
        end
      end
      WRITE: begin
        if (dfp_resp) begin
          ufp_resp = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are pure decodes of the registered state and request.
  always_comb begin
    dfp_read  = (state_q == FETCH);
    dfp_write = (state_q == WRITE);
    dfp_addr  = 32'h0;
    dfp_wmask = 4'h0;
    dfp_wdata = 32'h0;
    if (state_q == FETCH) begin
      dfp_addr = {addr_q[31:5], 5'b0};
    end else if (state_q == WRITE) begin
      dfp_addr  = {addr_q[31:2], 2'b0};
      dfp_wmask = wmask_q;
      dfp_wdata = wdata_q;
    end
  end

  // Reset clears only state and valid bits; an edge under reset installs nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      is_write_q <= is_write_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed scenarios plus randomized traffic
// compared every cycle against a behavioural cache/memory model.
module tb_dcache_responder;

  logic         clk;
  logic         rst;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [3:0]   ufp_wmask;
  logic [31:0]  ufp_wdata;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [3:0]   dfp_wmask;
  logic [31:0]  dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;

  dcache_responder #(.SETS(16), .LINE_BITS(256)) dut (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask), .ufp_wdata(ufp_wdata),
    .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wmask(dfp_wmask), .dfp_wdata(dfp_wdata),
    .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: memory as a sparse word map, cache as per-set arrays.
  logic [31:0] memw [logic [31:0]];
  logic        mvalid [16];
  logic [22:0] mtag [16];
  logic [31:0] mdata [16][8];

  logic        chk_en;
  logic        exp_resp, exp_rd, exp_dread, exp_dwrite;
  logic [31:0] exp_rdata, exp_daddr, exp_wdata;
  logic [3:0]  exp_wmask;
  logic [31:0] last_rdata, last_daddr;
  logic        last_hit;

  localparam logic [31:0] SENT = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (memw.exists(a)) return memw[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word({a[31:5], 5'b0} + 32'(4 * w));
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = $urandom;
    return l;
  endfunction

  // Per-cycle comparison against the expectations the driver publishes for this cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ufp_resp", 32'(ufp_resp), 32'(exp_resp));
      check("dfp_read", 32'(dfp_read), 32'(exp_dread));
      check("dfp_write", 32'(dfp_write), 32'(exp_dwrite));
      if (exp_resp && exp_rd) check("ufp_rdata", ufp_rdata, exp_rdata);
      if (exp_dread || exp_dwrite) check("dfp_addr", dfp_addr, exp_daddr);
      if (exp_dwrite) begin
        check("dfp_wmask", 32'(dfp_wmask), 32'(exp_wmask));
        check("dfp_wdata", dfp_wdata, exp_wdata);
      end
    end
    if (ufp_resp) last_rdata = ufp_rdata;
    if (dfp_read || dfp_write) last_daddr = dfp_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp();
    exp_resp = 1'b0; exp_rd = 1'b0; exp_dread = 1'b0; exp_dwrite = 1'b0;
    exp_rdata = 32'h0; exp_daddr = 32'h0; exp_wmask = 4'h0; exp_wdata = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      dfp_resp  = ($urandom_range(0, 2) == 0);
      dfp_rdata = rand_line();
      step();
    end
    dfp_resp = 1'b0;
  endtask

  // One CPU transaction; memory answers d cycles after its request first appears.
  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input int d);
    logic        is_w, hit;
    int          idx;
    logic [22:0] tg;
    logic [2:0]  off;
    is_w = (wm != 4'h0);
    idx  = int'(a[8:5]);
    tg   = a[31:9];
    off  = a[4:2];
    hit  = mvalid[idx] && (mtag[idx] == tg);
    last_hit  = hit;
    ufp_addr  = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
    clr_exp();
    step();
    if (!is_w && hit) begin
      exp_resp = 1'b1; exp_rd = 1'b1; exp_rdata = mdata[idx][off];
      step();
    end else begin
      if (is_w && hit) mdata[idx][off] = merge(mdata[idx][off], wm, wd);
      step();
      for (int k = 0; k <= d; k++) begin
        exp_dread  = !is_w;
        exp_dwrite = is_w;
        exp_daddr  = is_w ? {a[31:2], 2'b00} : {a[31:5], 5'b0};
        exp_wmask  = is_w ? wm : 4'h0;
        exp_wdata  = is_w ? wd : 32'h0;
        exp_resp   = is_w && (k == d);
        dfp_resp   = (k == d);
        dfp_rdata  = (!is_w && k == d) ? line_of(a) : rand_line();
        step();
      end
      dfp_resp = 1'b0;
      clr_exp();
      if (is_w) begin
        memw[{a[31:2], 2'b00}] = merge(mem_word({a[31:2], 2'b00}), wm, wd);
      end else begin
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
        for (int w = 0; w < 8; w++) mdata[idx][w] = mem_word({a[31:5], 5'b0} + 32'(4 * w));
        exp_resp = 1'b1; exp_rd = 1'b1; exp_rdata = mdata[idx][off];
        step();
      end
    end
    ufp_rmask = 4'h0; ufp_wmask = 4'h0;
    clr_exp();
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  rm, wm;
    int          kind;
    rst = 1'b1; ufp_addr = 32'h0; ufp_rmask = 4'h0; ufp_wmask = 4'h0; ufp_wdata = 32'h0;
    dfp_rdata = '0; dfp_resp = 1'b0; chk_en = 1'b0;
    last_rdata = 32'h0; last_daddr = SENT; last_hit = 1'b0;
    clr_exp();
    for (int i = 0; i < 16; i++) begin mvalid[i] = 1'b0; mtag[i] = 23'h0; end
    memw[32'h0000_1004] = 32'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Cold read miss, then hit.
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 2);
    check("miss_fill_addr", last_daddr, 32'h0000_1000);
    check("miss_rdata", last_rdata, 32'hDEAD_BEEF);
    last_daddr = SENT;
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 0);
    check("hit_no_mem", last_daddr, SENT);
    check("hit_rdata", last_rdata, 32'hDEAD_BEEF);

    // Partial write hit then read back merged word.
    do_req(32'h0000_1004, 4'h0, 4'b0011, 32'h1234_5678, 1);
    check("wt_addr", last_daddr, 32'h0000_1004);
    last_daddr = SENT;
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 0);
    check("merge_rdata", last_rdata, 32'hDEAD_5678);
    check("merge_no_mem", last_daddr, SENT);

    // Write miss does not allocate.
    do_req(32'h0000_2008, 4'h0, 4'hF, 32'hCAFE_F00D, 0);
    check("wmiss_addr", last_daddr, 32'h0000_2008);
    do_req(32'h0000_2008, 4'hF, 4'h0, 32'h0, 1);
    check("wmiss_then_fill", last_daddr, 32'h0000_2000);
    check("wmiss_rdata", last_rdata, 32'hCAFE_F00D);

    // Conflict misses on set 0.
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 0);
    check("conf_fill1", last_daddr, 32'h0000_1000);
    check("conf_rdata1", last_rdata, 32'hDEAD_5678);
    do_req(32'h0000_3004, 4'hF, 4'h0, 32'h0, 3);
    check("conf_fill2", last_daddr, 32'h0000_3000);
    last_daddr = SENT;
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 0);
    check("conf_refill", last_daddr, 32'h0000_1000);

    // Reset in the middle of a fill to set 1, then a stray memory response.
    ufp_addr = 32'h0000_5024; ufp_rmask = 4'hF; clr_exp();
    step();
    step();
    exp_dread = 1'b1; exp_daddr = 32'h0000_5020;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; ufp_rmask = 4'h0; clr_exp();
    dfp_resp = 1'b1; dfp_rdata = line_of(32'h0000_5024);
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    step();
    dfp_resp = 1'b0;
    check("rst_dfp_read", 32'(dfp_read), 32'h0);
    check("rst_ufp_resp", 32'(ufp_resp), 32'h0);
    idle(3);
    last_daddr = SENT;
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 1);
    check("rst_invalidates", last_daddr, 32'h0000_1000);
    last_daddr = SENT;
    do_req(32'h0000_5024, 4'hF, 4'h0, 32'h0, 0);
    check("rst_no_install", last_daddr, 32'h0000_5020);

    // Randomized traffic over a small footprint to mix hits, misses and conflicts.
    for (int t = 0; t < 400; t++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5) |
          (32'($urandom_range(0, 7)) << 2);
      kind = $urandom_range(0, 9);
      rm = 4'($urandom_range(1, 15));
      wm = 4'($urandom_range(1, 15));
      if (kind < 6) wm = 4'h0;
      else if (kind < 9) rm = 4'h0;
      do_req(a, rm, wm, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
